// File: rtl/huffman_token_sequencer.sv
// Feeds LZ77 tokens to the static DEFLATE Huffman encoder and queues its results
// in a small credit-gated FIFO toward the bit packer.
module huffman_token_sequencer #(
    parameter int unsigned OUT_DEPTH = 2,
    parameter int unsigned EOB_BITS  = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tok_valid,
    output logic        tok_ready,
    input  logic        tok_eob,
    input  logic        tok_is_pair,
    input  logic [7:0]  tok_literal,
    input  logic [8:0]  tok_length,
    input  logic [14:0] tok_distance,
    output logic        enc_literal,
    output logic        enc_length,
    output logic        enc_distance,
    output logic [7:0]  enc_literal_data,
    output logic [8:0]  enc_length_data,
    output logic [14:0] enc_distance_data,
    input  logic [17:0] enc_data_out,
    input  logic [4:0]  enc_valid_bits,
    output logic        code_valid,
    input  logic        code_ready,
    output logic [17:0] code_data,
    output logic [4:0]  code_bits,
    output logic        err_sticky
);

    localparam int unsigned PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CW = $clog2(OUT_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LIT,
        S_LEN,
        S_DIST,
        S_EOB
    } state_t;

    state_t          state, state_nx;
    logic            pending;
    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [22:0]     mem [OUT_DEPTH];

    logic            pop;
    logic            credit_ok;
    logic            strobe;
    logic            eob_push;
    logic            cap_push;
    logic            push;
    logic [22:0]     push_word;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == OUT_DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign code_valid = (count != '0);
    assign code_data  = mem[rd_ptr][22:5];
    assign code_bits  = mem[rd_ptr][4:0];
    assign pop        = code_valid & code_ready;

    // The in-flight encoder result already owns a slot, so it counts against credit.
    assign credit_ok  = (32'(count) + 32'(pending)) < (OUT_DEPTH + 32'(pop));

    assign strobe     = enc_literal | enc_length | enc_distance;
    assign cap_push   = pending && (enc_valid_bits != '0);
    assign push       = cap_push | eob_push;
    assign push_word  = eob_push ? {18'd0, 5'(EOB_BITS)} : {enc_data_out, enc_valid_bits};

    always_comb begin
        state_nx     = state;
        enc_literal  = 1'b0;
        enc_length   = 1'b0;
        enc_distance = 1'b0;
        eob_push     = 1'b0;
        tok_ready    = (state == S_IDLE) && !reset;
        unique case (state)
            S_IDLE: begin
                if (tok_valid) begin
                    if (tok_eob)          state_nx = S_EOB;
                    else if (tok_is_pair) state_nx = S_LEN;
                    else                  state_nx = S_LIT;
                end
            end
            S_LIT: begin
                if (credit_ok) begin
                    enc_literal = 1'b1;
                    state_nx    = S_IDLE;
                end
            end
            S_LEN: begin
                if (credit_ok) begin
                    enc_length = 1'b1;
                    state_nx   = S_DIST;
                end
            end
            S_DIST: begin
                if (credit_ok) begin
                    enc_distance = 1'b1;
                    state_nx     = S_IDLE;
                end
            end
            S_EOB: begin
                // Waiting out any in-flight result keeps EOB behind the last code.
                if (!pending && credit_ok) begin
                    eob_push = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            pending           <= 1'b0;
            err_sticky        <= 1'b0;
            enc_literal_data  <= '0;
            enc_length_data   <= '0;
            enc_distance_data <= '0;
        end else begin
            state   <= state_nx;
            pending <= strobe;
            if (pending && (enc_valid_bits == '0))
                err_sticky <= 1'b1;
            if (tok_valid && tok_ready) begin
                enc_literal_data  <= tok_literal;
                enc_length_data   <= tok_length;
                enc_distance_data <= tok_distance;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < OUT_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                count <= count + CW'(1);
            else if (!push && pop)
                count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_huffman_token_sequencer.sv
// Directed bench for huffman_token_sequencer with a small static-Huffman encoder model
// (literal L<144 -> 0x30+L/8 bits, length n -> n-2/7 bits, distance d -> d-1/5 bits).
module tb_huffman_token_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tok_valid = 1'b0;
    logic        tok_ready;
    logic        tok_eob = 1'b0;
    logic        tok_is_pair = 1'b0;
    logic [7:0]  tok_literal = '0;
    logic [8:0]  tok_length = '0;
    logic [14:0] tok_distance = '0;
    logic        enc_literal, enc_length, enc_distance;
    logic [7:0]  enc_literal_data;
    logic [8:0]  enc_length_data;
    logic [14:0] enc_distance_data;
    logic [17:0] enc_data_out = '0;
    logic [4:0]  enc_valid_bits = '0;
    logic        code_valid;
    logic        code_ready = 1'b0;
    logic [17:0] code_data;
    logic [4:0]  code_bits;
    logic        err_sticky;

    logic        zero_len = 1'b0;
    int          lit_cnt = 0;
    int          passes = 0;
    int          checks = 0;
    int          lit_base;

    huffman_token_sequencer #(.OUT_DEPTH(2), .EOB_BITS(7)) dut (
        .clock             (clock),
        .reset             (reset),
        .tok_valid         (tok_valid),
        .tok_ready         (tok_ready),
        .tok_eob           (tok_eob),
        .tok_is_pair       (tok_is_pair),
        .tok_literal       (tok_literal),
        .tok_length        (tok_length),
        .tok_distance      (tok_distance),
        .enc_literal       (enc_literal),
        .enc_length        (enc_length),
        .enc_distance      (enc_distance),
        .enc_literal_data  (enc_literal_data),
        .enc_length_data   (enc_length_data),
        .enc_distance_data (enc_distance_data),
        .enc_data_out      (enc_data_out),
        .enc_valid_bits    (enc_valid_bits),
        .code_valid        (code_valid),
        .code_ready        (code_ready),
        .code_data         (code_data),
        .code_bits         (code_bits),
        .err_sticky        (err_sticky)
    );

    always #5 clock = ~clock;

    // Encoder stand-in: result one cycle after the strobe, holds otherwise.
    always @(posedge clock) begin
        if (enc_literal) begin
            enc_data_out   <= 18'h30 + 18'(enc_literal_data);
            enc_valid_bits <= 5'd8;
        end else if (enc_length) begin
            enc_data_out   <= 18'(enc_length_data) - 18'd2;
            enc_valid_bits <= zero_len ? 5'd0 : 5'd7;
        end else if (enc_distance) begin
            enc_data_out   <= 18'(enc_distance_data) - 18'd1;
            enc_valid_bits <= 5'd5;
        end
    end

    always @(posedge clock) begin
        if (enc_literal) lit_cnt <= lit_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic no_strobes(input string tag);
        check(tag, 32'({enc_literal, enc_length, enc_distance}), 32'd0);
    endtask

    initial begin
        // Reset state
        cyc(); settle();
        check("rst_tok_ready", 32'(tok_ready), 32'd0);
        check("rst_code_valid", 32'(code_valid), 32'd0);
        no_strobes("rst_strobes");
        check("rst_err", 32'(err_sticky), 32'd0);
        check("rst_lit_data", 32'(enc_literal_data), 32'd0);
        reset = 1'b0;
        settle();
        check("idle_tok_ready", 32'(tok_ready), 32'd1);

        // Literal 0x41
        cyc();
        code_ready = 1'b1;
        lit_base = lit_cnt;
        tok_valid = 1'b1; tok_is_pair = 1'b0; tok_eob = 1'b0; tok_literal = 8'h41;
        settle();
        check("lit_accept_ready", 32'(tok_ready), 32'd1);
        cyc(); tok_valid = 1'b0; settle();
        check("lit_strobe", 32'(enc_literal), 32'd1);
        check("lit_busy", 32'(tok_ready), 32'd0);
        check("lit_data", 32'(enc_literal_data), 32'h41);
        cyc(); settle();
        check("lit_single_pulse", 32'(enc_literal), 32'd0);
        check("lit_not_yet_valid", 32'(code_valid), 32'd0);
        cyc(); settle();
        check("lit_code_valid", 32'(code_valid), 32'd1);
        check("lit_code_data", 32'(code_data), 32'h71);
        check("lit_code_bits", 32'(code_bits), 32'd8);
        cyc(); settle();
        check("lit_drained", 32'(code_valid), 32'd0);
        check("lit_count", 32'(lit_cnt - lit_base), 32'd1);

        // Pair length=3 distance=1
        cyc();
        tok_valid = 1'b1; tok_is_pair = 1'b1; tok_length = 9'd3; tok_distance = 15'd1;
        settle();
        check("pair_accept_ready", 32'(tok_ready), 32'd1);
        cyc(); tok_valid = 1'b0; tok_is_pair = 1'b0; settle();
        check("pair_len_strobe", 32'({enc_literal, enc_length, enc_distance}), 32'b010);
        check("pair_busy1", 32'(tok_ready), 32'd0);
        cyc(); settle();
        check("pair_dist_strobe", 32'({enc_literal, enc_length, enc_distance}), 32'b001);
        check("pair_busy2", 32'(tok_ready), 32'd0);
        cyc(); settle();
        no_strobes("pair_strobes_done");
        check("pair_ready_again", 32'(tok_ready), 32'd1);
        check("pair_len_code", 32'({code_valid, code_data, code_bits}), 32'({1'b1, 18'd1, 5'd7}));
        cyc(); settle();
        check("pair_dist_code", 32'({code_valid, code_data, code_bits}), 32'({1'b1, 18'd0, 5'd5}));
        cyc(); settle();
        check("pair_drained", 32'(code_valid), 32'd0);

        // Literal followed at once by EOB
        cyc();
        tok_valid = 1'b1; tok_literal = 8'h41;
        cyc(); tok_valid = 1'b0; settle();
        check("eob_lit_strobe", 32'(enc_literal), 32'd1);
        cyc();
        tok_valid = 1'b1; tok_eob = 1'b1;
        settle();
        check("eob_accept_ready", 32'(tok_ready), 32'd1);
        cyc(); tok_valid = 1'b0; tok_eob = 1'b0; settle();
        no_strobes("eob_no_strobe");
        check("eob_first_code", 32'({code_valid, code_data, code_bits}), 32'({1'b1, 18'h71, 5'd8}));
        cyc(); settle();
        check("eob_code", 32'({code_valid, code_data, code_bits}), 32'({1'b1, 18'd0, 5'd7}));
        cyc(); settle();
        check("eob_drained", 32'(code_valid), 32'd0);
        check("eob_idle", 32'(tok_ready), 32'd1);

        // Backpressure: three literals with code_ready low
        cyc();
        code_ready = 1'b0;
        lit_base = lit_cnt;
        tok_valid = 1'b1; tok_literal = 8'h41;
        cyc(); settle();
        check("bp_strobe1", 32'(enc_literal), 32'd1);
        tok_literal = 8'h42;
        cyc(); settle();
        check("bp_accept2", 32'(tok_ready), 32'd1);
        cyc(); settle();
        check("bp_strobe2", 32'(enc_literal), 32'd1);
        tok_literal = 8'h43;
        cyc(); settle();
        check("bp_accept3", 32'(tok_ready), 32'd1);
        cyc(); tok_valid = 1'b0; settle();
        check("bp_stall", 32'(enc_literal), 32'd0);
        check("bp_stall_busy", 32'(tok_ready), 32'd0);
        check("bp_head", 32'({code_valid, code_data}), 32'({1'b1, 18'h71}));
        cyc(); settle();
        check("bp_still_stalled", 32'(enc_literal), 32'd0);
        check("bp_two_strobes", 32'(lit_cnt - lit_base), 32'd2);
        code_ready = 1'b1;
        settle();
        check("bp_release_strobe", 32'(enc_literal), 32'd1);
        check("bp_out1", 32'({code_valid, code_data, code_bits}), 32'({1'b1, 18'h71, 5'd8}));
        cyc(); settle();
        check("bp_out2", 32'({code_valid, code_data, code_bits}), 32'({1'b1, 18'h72, 5'd8}));
        cyc(); settle();
        check("bp_out3", 32'({code_valid, code_data, code_bits}), 32'({1'b1, 18'h73, 5'd8}));
        cyc(); settle();
        check("bp_drained", 32'(code_valid), 32'd0);
        check("bp_three_strobes", 32'(lit_cnt - lit_base), 32'd3);

        // Encoder reports zero bits for a length
        cyc();
        zero_len = 1'b1;
        tok_valid = 1'b1; tok_is_pair = 1'b1; tok_length = 9'd4; tok_distance = 15'd2;
        cyc(); tok_valid = 1'b0; tok_is_pair = 1'b0; settle();
        check("zl_len_strobe", 32'(enc_length), 32'd1);
        cyc(); settle();
        check("zl_dist_strobe", 32'(enc_distance), 32'd1);
        cyc(); zero_len = 1'b0; settle();
        check("zl_err_set", 32'(err_sticky), 32'd1);
        check("zl_dropped", 32'(code_valid), 32'd0);
        cyc(); settle();
        check("zl_dist_code", 32'({code_valid, code_data, code_bits}), 32'({1'b1, 18'd1, 5'd5}));
        cyc(); settle();
        check("zl_drained", 32'(code_valid), 32'd0);
        tok_valid = 1'b1; tok_literal = 8'h42;
        cyc(); tok_valid = 1'b0; settle();
        check("zl_next_strobe", 32'(enc_literal), 32'd1);
        cyc(); cyc(); settle();
        check("zl_next_code", 32'({code_valid, code_data, code_bits}), 32'({1'b1, 18'h72, 5'd8}));
        check("zl_err_holds", 32'(err_sticky), 32'd1);
        cyc();

        // Reset while stalled in DIST with one entry queued
        code_ready = 1'b0;
        tok_valid = 1'b1; tok_literal = 8'h41;
        cyc(); tok_valid = 1'b0; settle();
        check("rs_lit_strobe", 32'(enc_literal), 32'd1);
        cyc();
        tok_valid = 1'b1; tok_is_pair = 1'b1; tok_length = 9'd3; tok_distance = 15'd1;
        cyc(); tok_valid = 1'b0; tok_is_pair = 1'b0; settle();
        check("rs_len_strobe", 32'(enc_length), 32'd1);
        cyc(); settle();
        check("rs_dist_stall", 32'(enc_distance), 32'd0);
        check("rs_one_queued", 32'({code_valid, code_data}), 32'({1'b1, 18'h71}));
        reset = 1'b1;
        settle();
        check("rs_code_valid", 32'(code_valid), 32'd0);
        no_strobes("rs_strobes");
        check("rs_tok_ready", 32'(tok_ready), 32'd0);
        check("rs_err_clear", 32'(err_sticky), 32'd0);
        cyc();
        reset = 1'b0;
        settle();
        check("rs_idle_ready", 32'(tok_ready), 32'd1);
        check("rs_empty", 32'(code_valid), 32'd0);
        cyc(); settle();
        no_strobes("rs_quiet");
        check("rs_still_empty", 32'(code_valid), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
